// File: rtl/lif_evt_pkg.sv
// Shared sizing and event-word layout for the LIF spike event encoder.
// The event word carries the neuron id in its MSB and the capture timestamp below it.
package lif_evt_pkg;
    localparam int N_NEURONS  = 2;
    localparam int TS_WIDTH   = 7;
    localparam int FIFO_DEPTH = 4;
    localparam int EVT_WIDTH  = 1 + TS_WIDTH;
    localparam int EVT_ID_BIT = TS_WIDTH;
    localparam int EVT_TS_MSB = TS_WIDTH - 1;
    localparam int EVT_TS_LSB = 0;

    typedef struct packed {
        logic                id;
        logic [TS_WIDTH-1:0] ts;
    } evt_word_t;

    function automatic evt_word_t make_evt(input logic id, input logic [TS_WIDTH-1:0] ts);
        evt_word_t w;
        w.id = id;
        w.ts = ts;
        return w;
    endfunction
endpackage

// File: rtl/evt_fifo.sv
// Event buffer: power-of-two circular FIFO whose occupancy count separates full from empty.
// No bypass: a pop on an empty buffer is ignored, and the head reads as zero while empty.
module evt_fifo
    import lif_evt_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  evt_word_t              wdata_i,
    output evt_word_t              rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    evt_word_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    // A push into a full buffer is allowed only when the head leaves on the same edge.
    always_comb begin
        empty_o  = (level_q == '0);
        full_o   = (level_q == (AW+1)'(DEPTH));
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        level_o  = level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/spike_event_encoder.sv
// Turns one-cycle neuron spike pulses into timestamped event words queued for a consumer.
// Each neuron holds one pending event; a spike arriving while it is still pending is counted as a drop.
module spike_event_encoder #(
    parameter int N_NEURONS  = lif_evt_pkg::N_NEURONS,
    parameter int TS_WIDTH   = lif_evt_pkg::TS_WIDTH,
    parameter int FIFO_DEPTH = lif_evt_pkg::FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic [N_NEURONS-1:0]               spike_in,
    output logic [lif_evt_pkg::EVT_WIDTH-1:0]  evt_data,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic [7:0]                         drop_count,
    input  logic                               clr_drop
);
    import lif_evt_pkg::*;

    localparam int ID_W  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int CNT_W = $clog2(N_NEURONS + 1);

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [TS_WIDTH-1:0]  pend_ts_q [N_NEURONS];
    logic [TS_WIDTH-1:0]  pend_ts_d [N_NEURONS];
    logic [7:0]           drop_q, drop_d;
    logic [N_NEURONS-1:0] cleared;
    logic [CNT_W-1:0]     n_drop;
    logic [8:0]           drop_sum;
    logic                 sel_valid;
    logic [ID_W-1:0]      sel_idx;
    logic                 push, pop, fifo_full, fifo_empty;
    evt_word_t            push_word, head_word;

    // Lowest-index pending neuron wins the single push slot of each edge.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_valid = 1'b1;
                sel_idx   = ID_W'(i);
            end
        end
        pop       = !fifo_empty && evt_ready;
        push      = sel_valid && (!fifo_full || pop);
        push_word = make_evt(sel_idx[0], pend_ts_q[sel_idx]);
    end

    // A spike on a neuron whose pending slot is freed this same edge re-arms it instead of dropping.
    always_comb begin
        pending_d = pending_q;
        pend_ts_d = pend_ts_q;
        cleared   = '0;
        n_drop    = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            cleared[i] = push && (sel_idx == ID_W'(i));
            if (cleared[i]) begin
                pending_d[i] = 1'b0;
            end
            if (ena && spike_in[i]) begin
                if (pending_q[i] && !cleared[i]) begin
                    n_drop = n_drop + CNT_W'(1);
                end else begin
                    pending_d[i] = 1'b1;
                    pend_ts_d[i] = ts_q;
                end
            end
        end
        ts_d     = ena ? ts_q + TS_WIDTH'(1) : ts_q;
        drop_sum = {1'b0, drop_q} + 9'(n_drop);
        if (clr_drop) begin
            drop_d = '0;
        end else if (drop_sum[8]) begin
            drop_d = 8'hFF;
        end else begin
            drop_d = drop_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q      <= '0;
            pending_q <= '0;
            drop_q    <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                pend_ts_q[i] <= '0;
            end
        end else begin
            ts_q      <= ts_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            pend_ts_q <= pend_ts_d;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_word),
        .rdata_o (head_word),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        evt_data                        = '0;
        evt_data[EVT_ID_BIT]            = head_word.id;
        evt_data[EVT_TS_MSB:EVT_TS_LSB] = head_word.ts;
        evt_valid                       = !fifo_empty;
        drop_count                      = drop_q;
    end
endmodule

// File: tb/tb_spike_event_encoder.sv
// Scenario bench for spike_event_encoder: expected event words are queued as spikes are driven
// and compared against evt_data whenever the consumer handshake completes.
module tb_spike_event_encoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] spike_in;
    logic [7:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] fifo_level;
    logic [7:0] drop_count;
    logic       clr_drop;

    int         errors = 0;
    int         checks = 0;
    logic [6:0] tsModel = '0;
    logic [7:0] expQ [$];

    spike_event_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .evt_data   (evt_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .clr_drop   (clr_drop)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; scores any handshake about to complete, then advances one cycle.
    task automatic stepClock();
        logic [7:0] exp;
        if (evt_valid && evt_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got evt_data=%02h, required no event", evt_data);
            end else begin
                exp = expQ.pop_front();
                if (evt_data !== exp) begin
                    errors++;
                    $display("[TB] FAIL sb_event: got evt_data=%02h, required %02h", evt_data, exp);
                end
            end
        end
        @(posedge clk);
        if (!rst_n) tsModel = '0;
        else if (ena) tsModel = tsModel + 7'd1;
        @(negedge clk);
    endtask

    task automatic doReset();
        evt_ready = 1'b0;
        spike_in  = 2'b00;
        clr_drop  = 1'b0;
        rst_n     = 1'b0;
        stepClock();
        rst_n = 1'b1;
        expQ.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; spike_in = 2'b11; evt_ready = 1'b0; clr_drop = 1'b0;
        stepClock();
        stepClock();
        rst_n = 1'b1; spike_in = 2'b00;
        expQ.delete();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", evt_valid); end
        checks++; if (evt_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %02h, required 00", evt_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d, required 0", fifo_level); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d, required 0", drop_count); end
        stepClock();
        stepClock();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_spike_ignored: got valid=%b, required 0", evt_valid); end
    endtask

    task automatic test_single_spike();
        doReset();
        ena = 1'b1; evt_ready = 1'b1;
        while (tsModel != 7'd5) stepClock();
        spike_in = 2'b01; expQ.push_back({1'b0, tsModel});
        stepClock();
        spike_in = 2'b00;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_latency: got valid=%b after capture edge, required 0", evt_valid); end
        stepClock();
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b, required 1", evt_valid); end
        checks++; if (evt_data !== 8'h05) begin errors++; $display("[TB] FAIL single_data: got %02h, required 05", evt_data); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL single_level: got %0d, required 1", fifo_level); end
        stepClock();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_one_cycle: got valid=%b, required 0", evt_valid); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL single_drain: got %0d pending, required 0", expQ.size()); end
    endtask

    task automatic test_simultaneous();
        doReset();
        ena = 1'b1; evt_ready = 1'b1;
        while (tsModel != 7'd10) stepClock();
        spike_in = 2'b11;
        expQ.push_back({1'b0, tsModel});
        expQ.push_back({1'b1, tsModel});
        stepClock();
        spike_in = 2'b00;
        stepClock();
        checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h0A) begin errors++; $display("[TB] FAIL simul_first: got valid=%b data=%02h, required 1/0A", evt_valid, evt_data); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL simul_level1: got %0d, required 1", fifo_level); end
        stepClock();
        checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h8A) begin errors++; $display("[TB] FAIL simul_second: got valid=%b data=%02h, required 1/8A", evt_valid, evt_data); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL simul_level2: got %0d, required 1", fifo_level); end
        stepClock();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_end: got valid=%b, required 0", evt_valid); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL simul_drop: got %0d, required 0", drop_count); end
    endtask

    task automatic test_backpressure();
        doReset();
        ena = 1'b1; evt_ready = 1'b0;
        while (tsModel != 7'd12) begin
            if (tsModel[0] && tsModel <= 7'd11) begin
                spike_in = 2'b01;
                if (tsModel != 7'd11) expQ.push_back({1'b0, tsModel});
            end else begin
                spike_in = 2'b00;
            end
            stepClock();
        end
        spike_in = 2'b00;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL bp_level_full: got %0d, required 4", fifo_level); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("[TB] FAIL bp_drop: got %0d, required 1", drop_count); end
        checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h01) begin errors++; $display("[TB] FAIL bp_head_stable: got valid=%b data=%02h, required 1/01", evt_valid, evt_data); end
        evt_ready = 1'b1;
        stepClock();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL bp_push_pop_full: got %0d, required 4", fifo_level); end
        for (int n = 0; n < 20 && evt_valid; n++) stepClock();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_timeout: got valid=%b, required 0", evt_valid); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL bp_missing: got %0d events outstanding, required 0", expQ.size()); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL bp_level_empty: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_wrap();
        doReset();
        ena = 1'b1; evt_ready = 1'b1;
        repeat (128) stepClock();
        spike_in = 2'b01; expQ.push_back({1'b0, tsModel});
        stepClock();
        spike_in = 2'b00;
        stepClock();
        checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h00) begin errors++; $display("[TB] FAIL wrap_event: got valid=%b data=%02h, required 1/00", evt_valid, evt_data); end
        stepClock();
        checks++; if (evt_valid !== 1'b0 || expQ.size() != 0) begin errors++; $display("[TB] FAIL wrap_drain: got valid=%b outstanding=%0d, required 0/0", evt_valid, expQ.size()); end
    endtask

    task automatic test_ena_freeze();
        doReset();
        ena = 1'b1; evt_ready = 1'b1;
        repeat (3) stepClock();
        spike_in = 2'b01; expQ.push_back({1'b0, tsModel});
        stepClock();
        ena = 1'b0; spike_in = 2'b00;
        stepClock();
        checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h03) begin errors++; $display("[TB] FAIL ena_push_unblocked: got valid=%b data=%02h, required 1/03", evt_valid, evt_data); end
        stepClock();
        spike_in = 2'b11;
        repeat (3) stepClock();
        spike_in = 2'b00;
        stepClock();
        checks++; if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL ena_spike_ignored: got valid=%b level=%0d, required 0/0", evt_valid, fifo_level); end
        ena = 1'b1; spike_in = 2'b10; expQ.push_back({1'b1, tsModel});
        stepClock();
        spike_in = 2'b00;
        stepClock();
        checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h84) begin errors++; $display("[TB] FAIL ena_ts_frozen: got valid=%b data=%02h, required 1/84", evt_valid, evt_data); end
        stepClock();
        checks++; if (evt_valid !== 1'b0 || expQ.size() != 0) begin errors++; $display("[TB] FAIL ena_drain: got valid=%b outstanding=%0d, required 0/0", evt_valid, expQ.size()); end
    endtask

    task automatic test_drop_saturate();
        doReset();
        ena = 1'b1; evt_ready = 1'b0; spike_in = 2'b11;
        repeat (6) stepClock();
        checks++; if (drop_count !== 8'd6) begin errors++; $display("[TB] FAIL drop_early: got %0d, required 6", drop_count); end
        repeat (294) stepClock();
        checks++; if (drop_count !== 8'd255) begin errors++; $display("[TB] FAIL drop_saturate: got %0d, required 255", drop_count); end
        clr_drop = 1'b1;
        stepClock();
        clr_drop = 1'b0;
        checks++; if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL drop_clear: got %0d, required 0", drop_count); end
        spike_in = 2'b00;
    endtask

    task automatic test_reset_mid();
        doReset();
        ena = 1'b1; evt_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            spike_in = (i % 2 == 0) ? 2'b01 : 2'b00;
            stepClock();
        end
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("[TB] FAIL mid_level3: got %0d, required 3", fifo_level); end
        rst_n = 1'b0; spike_in = 2'b11;
        stepClock();
        checks++; if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL mid_flush: got valid=%b level=%0d, required 0/0", evt_valid, fifo_level); end
        checks++; if (evt_data !== 8'h00 || drop_count !== 8'd0) begin errors++; $display("[TB] FAIL mid_outputs: got data=%02h drop=%0d, required 00/0", evt_data, drop_count); end
        rst_n = 1'b1; evt_ready = 1'b1; spike_in = 2'b01;
        expQ.delete();
        expQ.push_back({1'b0, tsModel});
        stepClock();
        spike_in = 2'b00;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_pending_discarded: got valid=%b, required 0", evt_valid); end
        stepClock();
        checks++; if (evt_valid !== 1'b1 || evt_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_ts_restart: got valid=%b data=%02h, required 1/00", evt_valid, evt_data); end
        for (int n = 0; n < 10 && evt_valid; n++) stepClock();
        checks++; if (evt_valid !== 1'b0 || expQ.size() != 0) begin errors++; $display("[TB] FAIL mid_drain: got valid=%b outstanding=%0d, required 0/0", evt_valid, expQ.size()); end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; spike_in = 2'b00; evt_ready = 1'b0; clr_drop = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_spike();
        test_simultaneous();
        test_backpressure();
        test_wrap();
        test_ena_freeze();
        test_drop_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter N_NEURONS, default 2, number of spike inputs; fixed at 2 in this revision.
REQ-002 Parameter TS_WIDTH, default 7, timestamp width; event word is 1+TS_WIDTH = 8 bits.
REQ-003 Parameter FIFO_DEPTH, default 4, event buffer depth; power of two.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  design enable; spikes and timestamp advance only when high.
REQ-007 spike_in  input  N_NEURONS  one-cycle spike pulses from the LIF neurons (bit i = neuron i).
REQ-008 evt_data  output  8  event word: [7] neuron id, [6:0] timestamp.
REQ-009 evt_valid  output  1  evt_data holds a valid event.
REQ-010 evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready.
REQ-011 fifo_level  output  3  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 drop_count  output  8  count of lost spikes, saturating.
REQ-013 clr_drop  input  1  synchronous clear of drop_count.

Function
REQ-014 Timestamp counter (TS_WIDTH bits) SHALL increment by 1 on each clock with ena=1, wrap 127->0, and hold when ena=0.
REQ-015 spike_in[i]=1 with ena=1 at an edge SHALL set pending[i] and capture the current timestamp into pend_ts[i].
REQ-016 Each edge, at most one pending event SHALL be pushed: lowest set index wins; pushed pending bit cleared the same edge.
REQ-017 Push SHALL occur only if the FIFO is not full, or is full and a pop occurs the same edge.
REQ-018 A spike on neuron i while pending[i] is set and not cleared that edge SHALL be dropped (pend_ts unchanged) and drop_count incremented.
REQ-019 A spike on neuron i at the same edge its pending event is pushed SHALL re-set pending[i] with the new timestamp; no drop.
REQ-020 Two drops on one edge SHALL add 2 to drop_count; drop_count SHALL saturate at 255.
REQ-021 clr_drop=1 SHALL load drop_count with 0, overriding increments that edge.
REQ-022 Uncontended latency: spike at edge k -> pending at k -> pushed at k+1 -> evt_valid high after edge k+1.
REQ-023 evt_valid SHALL equal (fifo_level != 0); evt_data SHALL be the FIFO head.
REQ-024 evt_data SHALL remain stable while evt_valid && !evt_ready.
REQ-025 Pop SHALL occur on edge with evt_valid && evt_ready; empty FIFO has no bypass (push and pop at empty: pop ignored, level becomes 1).
REQ-026 Simultaneous push and pop on a non-empty FIFO SHALL leave fifo_level unchanged.
REQ-027 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full distinguished from empty by level count.
REQ-028 ena=0 SHALL not block FIFO push/pop or handshake; only spike capture and timestamp freeze.

Reset
REQ-029 rst_n=0 at an edge SHALL clear timestamp, pending bits, pend_ts, FIFO pointers, fifo_level, drop_count.
REQ-030 After reset: evt_valid=0, evt_data=0, fifo_level=0, drop_count=0.
REQ-031 Reset mid-operation SHALL discard buffered and pending events; spikes during reset are ignored.

Structure
REQ-032 Shared package lif_evt_pkg SHALL hold TS_WIDTH, N_NEURONS, FIFO_DEPTH, event-word field positions and the event word type.
REQ-033 FIFO SHALL be a sub-module evt_fifo (push/pop/data/level/full/empty); arbitration, pending and timestamp logic in the top.

Verification
REQ-034 Single spike: reset, ena=1, spike_in=01 at ts=5, ready=1 -> evt_data=0x05 with evt_valid two edges later, one cycle only.
REQ-035 Simultaneous: spike_in=11 at ts=10, ready=1 -> events 0x0A then 0x8A on consecutive cycles, drop_count=0.
REQ-036 Backpressure: ready=0, spikes on neuron 0 at ts 1,3,5,7,9,11 -> fifo_level=4, one pending, next spike dropped, drop_count=1; first pop returns 0x01.
REQ-037 Wrap: ena=1 for 130 cycles, spike at 129th edge -> timestamp field 0x00 region correct (ts=128 mod 128=0), event 0x00.
REQ-038 Saturation/clear: force 300 drops -> drop_count=255; clr_drop pulse -> 0 next cycle.
REQ-039 Reset mid-operation: FIFO at level 3, assert rst_n=0 one edge -> evt_valid=0, fifo_level=0, timestamp=0 next cycle.
